strange_device_bank: RTL
========================

Name: strange_device_bank

Overview:
- N-channel digit bank: successor to the 4-device strange-device top level, with arbitrary channel count and self-contained per-channel history.
- One channel is selected at a time. It receives edge-detected load, change and mode events.
- Each channel drives one 7-seg digit plus a dot.
- The bank locks when every channel is in history mode showing the same digit. It leaves lock on an explicit unlock event instead of needing reset.

Parameters:
- CHANNEL_NUM, 4, number of channels (1..16, need not be a power of 2)
- SEL_WIDTH, 2, width of channel_choice; 2**SEL_WIDTH >= CHANNEL_NUM
- DIGIT_NUM, 7, one-hot digit input width (2..10)
- HISTORY_DEPTH, 4, history ring entries per channel (2..16)
- LOCK_TIMEOUT_CYCLES, 1000, auto-unlock delay; used only with LOCK_TIMEOUT_EN

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- channel_choice  in  SEL_WIDTH  selected channel
- digit_choice  in  DIGIT_NUM  digit select; the lowest set bit gives the value
- digit_load  in  1  button: load digit into selected channel
- digit_change  in  1  button: step back through history
- mode_change  in  1  button: toggle live/history
- unlock  in  1  button: leave LOCKED
- displays_flattened  out  CHANNEL_NUM*8  per channel {dot, seg[6:0]}; channel j at [8j +: 8]; active-low
- digit_load_indicator  out  1  selected channel's history is full
- locked  out  1  high in LOCKED

Behaviour:
- Edge detection: each button goes through rising_edge_detector. An event is a one-cycle pulse, high on the first clk edge where the input is 1 and was 0 at the previous edge. A held button gives one event.
- Per-channel state:
  - cur value
  - ring[HISTORY_DEPTH]
  - wr pointer
  - count (0..HISTORY_DEPTH, saturating)
  - mode (0 live, 1 history)
  - rd pointer
- Load event: ignored if digit_choice is 0. Otherwise value = index of the lowest set bit. ring[wr]=value, wr=wr+1 mod HISTORY_DEPTH, count=min(count+1,HISTORY_DEPTH), cur=value.
- Mode event: toggles mode. On entering history, rd = newest entry, including a value loaded in the same cycle.
- Change event:
  - Only in history mode with count>0: rd steps to the next older entry.
  - Wraps from the oldest valid entry to the newest; only count entries are visited.
  - Ignored in live mode, or when a mode event occurs in the same cycle.
- Display value: cur in live mode, ring[rd] in history mode.
- Blank (seg=7'h7F) when count==0.
- Seg code, gfedcba active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Dot: 0 (lit) only for the selected channel in RUNNING; 1 otherwise.
- channel_choice >= CHANNEL_NUM: no channel receives events, no dot lit, digit_load_indicator=0.
- digit_load_indicator = (count==HISTORY_DEPTH) of the selected channel, in both states.
- FSM RUNNING/LOCKED:
  - RUNNING to LOCKED at the next edge when lock_cond holds.
  - lock_cond: all channels in history mode, all count>0, all displayed values equal; computed from registered state.
  - Events arriving in a cycle where lock_cond holds are discarded; lock has priority.
- LOCKED:
  - All load/change/mode events ignored; all dots 1; locked=1.
  - An unlock event returns to RUNNING and forces every channel to live mode at that edge. History, count and cur are kept.
  - Unlock events in RUNNING are ignored.
- Reset (async, any time, including mid-lock):
  - RUNNING; all channels count=0, mode=0, pointers 0, cur=0.
  - Outputs: every seg 7'h7F; dot of the selected channel 0, others 1; locked=0; digit_load_indicator=0.
  - Edge-detector history is cleared, so a button already held at reset release gives no event.

Optional Feature:
- LOCK_TIMEOUT_EN defined:
  - A counter starts at 0 on entering LOCKED.
  - When it reaches LOCK_TIMEOUT_CYCLES-1, the next edge auto-unlocks, with the same effect as an unlock event.
  - An unlock event first also unlocks; the counter clears.
- Undefined: no counter; only unlock or reset leaves LOCKED.

Decomposition:
- Package strange_bank_pkg: FSM state encoding, SEG_BLANK constant, seg-encode function (value to 7-bit code).
- Sub-module bank_channel: one channel's ring, pointers, mode and display.
  - Inputs: load/change/mode pulses, value, force_live.
  - Outputs: seg, mode, valid, full, shown value.
- The top does event routing, lock detection, the FSM and flattening.

Test Plan:
- Reset, select ch0, digit_choice=7'b0001000, load -> ch0 seg=0110000 after one edge; other channels 7'h7F; ch0 dot 0.
- ch1: load 1,2,3,4,5, then mode, then change x4 -> shows 5,4,3,2,5; indicator=1 after the 4th load.
- All 4 channels load 2; enter history in ch0..ch2 -> stays RUNNING; mode on ch3 -> locked=1 next cycle. Then a load on ch0 is ignored; unlock -> RUNNING, all channels live showing 2.
- channel_choice=3 with CHANNEL_NUM=3 -> no dot lit, load ignored, indicator=0.
- Load and mode on the same channel in the same cycle -> history mode showing the newly loaded digit. Change and mode in the same cycle -> change ignored.
- rst low while LOCKED -> immediately locked=0, all segs blank. With LOCK_TIMEOUT_EN and LOCK_TIMEOUT_CYCLES=5 -> auto-unlock 5 cycles after entering LOCKED.

Source files
------------

// File: rtl/strange_bank_pkg.sv
// Shared types and seven-segment helpers for the strange_device_bank digit bank.
package strange_bank_pkg;

  typedef enum logic [0:0] {
    ST_RUNNING = 1'b0,
    ST_LOCKED  = 1'b1
  } bank_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // gfedcba, active-low; out-of-range values render blank
  function automatic logic [6:0] seg_encode(input logic [3:0] value);
    case (value)
      4'd0:    seg_encode = 7'b1000000;
      4'd1:    seg_encode = 7'b1111001;
      4'd2:    seg_encode = 7'b0100100;
      4'd3:    seg_encode = 7'b0110000;
      4'd4:    seg_encode = 7'b0011001;
      4'd5:    seg_encode = 7'b0010010;
      4'd6:    seg_encode = 7'b0000010;
      4'd7:    seg_encode = 7'b1111000;
      4'd8:    seg_encode = 7'b0000000;
      4'd9:    seg_encode = 7'b0010000;
      default: seg_encode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bank_channel.sv
// One digit channel: history ring, live/history mode, read pointer and segment output.
module bank_channel
  import strange_bank_pkg::*;
#(
  parameter int HISTORY_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       change,
  input  logic       mode_toggle,
  input  logic [3:0] value,
  input  logic       force_live,
  output logic [6:0] seg,
  output logic       mode,
  output logic       valid,
  output logic       full,
  output logic [3:0] shown
);

  localparam int PW = (HISTORY_DEPTH > 1) ? $clog2(HISTORY_DEPTH) : 1;
  localparam int CW = $clog2(HISTORY_DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(HISTORY_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(HISTORY_DEPTH);

  logic [3:0]    ring [HISTORY_DEPTH];
  logic [PW-1:0] wr, rd, newest, oldest, rd_older;
  logic [CW-1:0] count;
  logic [3:0]    cur;

  always_comb begin
    newest   = (wr == '0) ? LAST : wr - PW'(1);
    oldest   = PW'((int'(wr) + HISTORY_DEPTH - int'(count)) % HISTORY_DEPTH);
    // Stepping past the oldest valid entry wraps to the newest one
    if (rd == oldest)   rd_older = newest;
    else if (rd == '0)  rd_older = LAST;
    else                rd_older = rd - PW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < HISTORY_DEPTH; i++) ring[i] <= '0;
      wr    <= '0;
      rd    <= '0;
      count <= '0;
      cur   <= '0;
      mode  <= 1'b0;
    end else begin
      if (load) begin
        ring[wr] <= value;
        wr       <= (wr == LAST) ? '0 : wr + PW'(1);
        cur      <= value;
        if (count != DEPTH_C) count <= count + CW'(1);
      end
      if (force_live) begin
        mode <= 1'b0;
      end else if (mode_toggle) begin
        mode <= ~mode;
        // A same-cycle load is the newest entry, and it lands at wr
        if (!mode) rd <= load ? wr : newest;
      end else if (change && mode && count != '0) begin
        rd <= rd_older;
      end
    end
  end

  assign shown = mode ? ring[rd] : cur;
  assign valid = (count != '0);
  assign full  = (count == DEPTH_C);
  assign seg   = valid ? seg_encode(shown) : SEG_BLANK;

endmodule

// File: rtl/rising_edge_detector.sv
// One-cycle pulse on the first clock edge that sees a button high after it was low.
module rising_edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic prev;

  // Resets to 1 so a button already held when reset releases yields no event
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev <= 1'b1;
    else      prev <= din;
  end

  assign pulse = din & ~prev;

endmodule

// File: rtl/strange_device_bank.sv
// N-channel digit bank with lock detection; define LOCK_TIMEOUT_EN to add auto-unlock
// after LOCK_TIMEOUT_CYCLES cycles in LOCKED.
module strange_device_bank
  import strange_bank_pkg::*;
#(
  parameter int CHANNEL_NUM         = 4,
  parameter int SEL_WIDTH           = 2,
  parameter int DIGIT_NUM           = 7,
  parameter int HISTORY_DEPTH       = 4,
  parameter int LOCK_TIMEOUT_CYCLES = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SEL_WIDTH-1:0]     channel_choice,
  input  logic [DIGIT_NUM-1:0]     digit_choice,
  input  logic                     digit_load,
  input  logic                     digit_change,
  input  logic                     mode_change,
  input  logic                     unlock,
  output logic [CHANNEL_NUM*8-1:0] displays_flattened,
  output logic                     digit_load_indicator,
  output logic                     locked
);

  bank_state_t state;
  logic load_ev, change_ev, mode_ev, unlock_ev;
  logic sel_valid, accept, lock_cond, release_lock, timeout_hit, digit_found;
  logic [3:0] value;
  logic [CHANNEL_NUM-1:0] ch_mode, ch_valid, ch_full;
  logic [3:0] ch_shown [CHANNEL_NUM];
  logic [6:0] ch_seg   [CHANNEL_NUM];

  rising_edge_detector u_red_load   (.clk(clk), .rst(rst), .din(digit_load),   .pulse(load_ev));
  rising_edge_detector u_red_change (.clk(clk), .rst(rst), .din(digit_change), .pulse(change_ev));
  rising_edge_detector u_red_mode   (.clk(clk), .rst(rst), .din(mode_change),  .pulse(mode_ev));
  rising_edge_detector u_red_unlock (.clk(clk), .rst(rst), .din(unlock),       .pulse(unlock_ev));

  always_comb begin
    value       = '0;
    digit_found = 1'b0;
    for (int unsigned i = 0; i < DIGIT_NUM; i++) begin
      if (digit_choice[i] && !digit_found) begin
        value       = 4'(i);
        digit_found = 1'b1;
      end
    end
  end

  always_comb begin
    lock_cond = 1'b1;
    for (int unsigned j = 0; j < CHANNEL_NUM; j++) begin
      if (!ch_mode[j] || !ch_valid[j] || ch_shown[j] != ch_shown[0]) lock_cond = 1'b0;
    end
  end

  assign sel_valid = int'(channel_choice) < CHANNEL_NUM;
  // Lock takes priority: events seen while lock_cond holds are dropped
  assign accept    = (state == ST_RUNNING) && !lock_cond;

`ifdef LOCK_TIMEOUT_EN
  localparam int TW = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] lock_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     lock_cnt <= '0;
    else if (state != ST_LOCKED || release_lock)  lock_cnt <= '0;
    else                                          lock_cnt <= lock_cnt + TW'(1);
  end

  assign timeout_hit = (state == ST_LOCKED) && (lock_cnt == TW'(LOCK_TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign release_lock = (state == ST_LOCKED) && (unlock_ev || timeout_hit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUNNING;
    end else begin
      case (state)
        ST_RUNNING: if (lock_cond)    state <= ST_LOCKED;
        ST_LOCKED:  if (release_lock) state <= ST_RUNNING;
        default:                      state <= ST_RUNNING;
      endcase
    end
  end

  for (genvar j = 0; j < CHANNEL_NUM; j++) begin : g_ch
    logic hit;
    assign hit = sel_valid && (channel_choice == SEL_WIDTH'(j));

    bank_channel #(.HISTORY_DEPTH(HISTORY_DEPTH)) u_channel (
      .clk        (clk),
      .rst        (rst),
      .load       (accept && hit && load_ev && digit_found),
      .change     (accept && hit && change_ev),
      .mode_toggle(accept && hit && mode_ev),
      .value      (value),
      .force_live (release_lock),
      .seg        (ch_seg[j]),
      .mode       (ch_mode[j]),
      .valid      (ch_valid[j]),
      .full       (ch_full[j]),
      .shown      (ch_shown[j])
    );

    assign displays_flattened[8*j +: 8] = {~(hit && state == ST_RUNNING), ch_seg[j]};
  end

  always_comb begin
    digit_load_indicator = 1'b0;
    for (int unsigned j = 0; j < CHANNEL_NUM; j++) begin
      if (sel_valid && channel_choice == SEL_WIDTH'(j) && ch_full[j]) digit_load_indicator = 1'b1;
    end
  end

  assign locked = (state == ST_LOCKED);

endmodule
